// File: rtl/run_controller.sv
// Run-control sequencer for the Tenyr core: staged reset/halt release, optional
// cycle budget, and saturating cycle/instruction counters for debug readout.
module run_controller #(
    parameter int unsigned RESET_CYCLES = 3,
    parameter int unsigned HALT_CYCLES  = 4,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [CNT_WIDTH-1:0] budget,
    input  logic                 ext_halt,
    input  logic                 insn_done,
    input  logic                 restart,
    output logic                 core_reset,
    output logic                 run_halt,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] insn_count
);

    // Halt must outlast reset by at least one edge so HOLD is never skipped.
    localparam int unsigned HEFF = (HALT_CYCLES > RESET_CYCLES) ? HALT_CYCLES : RESET_CYCLES + 1;
    localparam int unsigned PW   = $clog2(HEFF + 1);

    localparam logic [PW-1:0]        RST_LAST  = PW'(RESET_CYCLES - 1);
    localparam logic [PW-1:0]        HOLD_LAST = PW'(HEFF - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {StRst, StHold, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        p_q, p_d;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] insn_q, insn_d;
    logic [CNT_WIDTH-1:0] run_q, run_d;
    logic [CNT_WIDTH-1:0] budget_q, budget_d;
    logic                 core_reset_q, core_reset_d;
    logic                 run_halt_q, run_halt_d;
    logic                 done_q, done_d;
    logic                 budget_hit;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign budget_hit = (budget_q != '0) && (run_q == budget_q - CNT_ONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StRst;
            p_q          <= '0;
            cycle_q      <= '0;
            insn_q       <= '0;
            run_q        <= '0;
            budget_q     <= '0;
            core_reset_q <= 1'b1;
            run_halt_q   <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            cycle_q      <= cycle_d;
            insn_q       <= insn_d;
            run_q        <= run_d;
            budget_q     <= budget_d;
            core_reset_q <= core_reset_d;
            run_halt_q   <= run_halt_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRst:   if (p_q == RST_LAST) state_d = StHold;
            StHold:  if (p_q == HOLD_LAST) state_d = StRun;
            StRun:   if (ext_halt || budget_hit) state_d = StDone;
            StDone:  if (restart) state_d = StRst;
            default: state_d = StRst;
        endcase
    end

    always_comb begin
        p_d      = p_q;
        cycle_d  = cycle_q;
        insn_d   = insn_q;
        run_d    = run_q;
        budget_d = budget_q;
        unique case (state_q)
            StRst, StHold: begin
                p_d     = p_q + 1'b1;
                cycle_d = sat_inc(cycle_q);
                if (state_d == StRun) begin
                    budget_d = budget;
                    run_d    = '0;
                end
            end
            StRun: begin
                cycle_d = sat_inc(cycle_q);
                run_d   = sat_inc(run_q);
                if (insn_done) insn_d = sat_inc(insn_q);
            end
            StDone: begin
                if (restart) begin
                    p_d     = '0;
                    cycle_d = '0;
                    insn_d  = '0;
                    run_d   = '0;
                end
            end
            default: ;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        core_reset_d = (state_d == StRst);
        run_halt_d   = (state_d != StRun);
        done_d       = (state_d == StDone);
    end

    assign core_reset  = core_reset_q;
    assign run_halt    = run_halt_q;
    assign done        = done_q;
    assign cycle_count = cycle_q;
    assign insn_count  = insn_q;

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: three parameterisations share clock and reset,
// stimulus queues hand-computed expectations, a negedge monitor compares them.
module tb_run_controller;

  typedef struct packed {
    int           id;
    logic [127:0] name;
    logic         cr;
    logic         rh;
    logic         dn;
    logic [31:0]  cc;
    logic [31:0]  ic;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] budget = 32'd10;
  logic        ext_halt = 1'b0;
  logic        insn_done = 1'b0;
  logic        restart = 1'b0;

  logic        cr0, rh0, d0, cr1, rh1, d1, cr2, rh2, d2;
  logic [31:0] cc0, ic0, cc1, ic1;
  logic [3:0]  cc2, ic2;

  always #5 clk = ~clk;

  run_controller dut0 (
    .clk(clk), .reset_n(reset_n), .budget(budget), .ext_halt(ext_halt),
    .insn_done(insn_done), .restart(restart), .core_reset(cr0), .run_halt(rh0),
    .done(d0), .cycle_count(cc0), .insn_count(ic0)
  );

  run_controller #(.RESET_CYCLES(5), .HALT_CYCLES(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .budget(32'd0), .ext_halt(1'b0),
    .insn_done(1'b0), .restart(1'b0), .core_reset(cr1), .run_halt(rh1),
    .done(d1), .cycle_count(cc1), .insn_count(ic1)
  );

  run_controller #(.CNT_WIDTH(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .budget(4'd0), .ext_halt(1'b0),
    .insn_done(1'b0), .restart(1'b0), .core_reset(cr2), .run_halt(rh2),
    .done(d2), .cycle_count(cc2), .insn_count(ic2)
  );

  task automatic expect_out(input int id, input logic [127:0] nm, input logic cr,
                            input logic rh, input logic dn, input int cc, input int ic);
    exp_t e;
    e.id = id; e.name = nm; e.cr = cr; e.rh = rh; e.dn = dn;
    e.cc = 32'(cc); e.ic = 32'(ic);
    sb.push_back(e);
  endtask

  task automatic expect_reset(input logic [127:0] nm);
    for (int d = 0; d < 3; d++) expect_out(d, nm, 1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic check_reset_now(input logic [127:0] nm);
    total++;
    if ({cr0, rh0, d0, cc0, ic0} !== {1'b1, 1'b1, 1'b0, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL %0s immediate: cr=%b rh=%b done=%b cc=%0d ic=%0d", nm, cr0, rh0, d0,
               cc0, ic0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic acr, arh, adn;
    logic [31:0] acc, aic;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.id)
        0:       begin acr = cr0; arh = rh0; adn = d0; acc = cc0; aic = ic0; end
        1:       begin acr = cr1; arh = rh1; adn = d1; acc = cc1; aic = ic1; end
        default: begin acr = cr2; arh = rh2; adn = d2; acc = 32'(cc2); aic = 32'(ic2); end
      endcase
      total++;
      if ({acr, arh, adn, acc, aic} !== {e.cr, e.rh, e.dn, e.cc, e.ic}) begin
        bad++;
        $display("FAIL %0s dut%0d got cr=%b rh=%b done=%b cc=%0d ic=%0d want cr=%b rh=%b done=%b cc=%0d ic=%0d",
                 e.name, e.id, acr, arh, adn, acc, aic, e.cr, e.rh, e.dn, e.cc, e.ic);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: wait expired before test completion");
    $finish;
  end

  initial begin
    #1 reset_n = 1'b0;
    #1 check_reset_now("por");
    repeat (2) @(posedge clk);
    #2 expect_reset("por");
    @(negedge clk);
    #1 reset_n = 1'b1;

    // Sequence 1: dut0 budget=10, insn every 2nd RUN edge plus stray pulses in RST and DONE.
    for (int k = 1; k <= 20; k++) begin
      insn_done = (k == 2) || (k == 5) || (k == 7) || (k == 9) || (k == 11) ||
                  (k == 13) || (k == 15);
      @(posedge clk);
      #2;
      expect_out(0, "seq_budget", k < 3, (k < 4) || (k > 13), k >= 14,
                 (k < 14) ? k : 14,
                 (k < 5) ? 0 : (((k - 5) / 2 + 1) < 5 ? (k - 5) / 2 + 1 : 5));
      if (k <= 16) expect_out(1, "rst5_halt2", k < 5, k < 6, 1'b0, k, 0);
      expect_out(2, "sat_w4", k < 3, k < 4, 1'b0, (k < 15) ? k : 15, 0);
    end

    insn_done = 1'b0;
    restart   = 1'b1;
    @(posedge clk);
    #2 restart = 1'b0;
    expect_out(0, "restart1", 1'b1, 1'b1, 1'b0, 0, 0);

    // Sequence 2: budget=100, ext_halt pulse on the HOLD edge ignored, restart in RUN ignored,
    // ext_halt held from the 3rd RUN edge.
    budget = 32'd100;
    for (int j = 1; j <= 9; j++) begin
      ext_halt  = (j == 4) || (j >= 7);
      restart   = (j == 5);
      insn_done = (j == 6);
      @(posedge clk);
      #2;
      expect_out(0, "seq_exthalt", j < 3, (j < 4) || (j > 6), j >= 7,
                 (j < 7) ? j : 7, (j >= 6) ? 1 : 0);
    end

    ext_halt  = 1'b0;
    insn_done = 1'b0;
    budget    = 32'd0;
    restart   = 1'b1;
    @(posedge clk);
    #2 restart = 1'b0;
    expect_out(0, "restart2", 1'b1, 1'b1, 1'b0, 0, 0);

    // Sequence 3: unlimited run, then asynchronous reset between edges.
    for (int j = 1; j <= 6; j++) begin
      insn_done = (j == 5);
      @(posedge clk);
      #2;
      expect_out(0, "seq_repeat", j < 3, j < 4, 1'b0, j, (j >= 5) ? 1 : 0);
    end
    insn_done = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_now("async_rst");
    expect_reset("async_rst");
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    if (bad != 0 || sb.size() != 0) begin
      $display("FAIL final: bad=%0d pending=%0d", bad, sb.size());
    end else begin
      $display("PASS");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
